// File: rtl/ptp_pkg.sv
// -----------------------------------------------------------------------------
// ptp_pkg
// Shared constants and types for the PTP message parser:
//   - Ethertypes recognised on the monitored stream (PTP, 802.1Q TPID)
//   - Ethernet header length and PTP header field offsets
//   - Parser FSM state enum
//   - Record struct (message type + sequenceId; the timestamp travels
//     alongside because its width is a parameter of the top module)
// -----------------------------------------------------------------------------
package ptp_pkg;

   localparam logic [15:0] PTP_ETHERTYPE   = 16'h88F7;
   localparam logic [15:0] VLAN_TPID       = 16'h8100;

   // Untagged Ethernet header length; PTP header starts right after it.
   localparam int          ETH_HDR_LEN     = 14;
   // Offsets inside the PTP common header.
   localparam int          PTP_MSGTYPE_OFF = 0;
   localparam int          PTP_SEQID_OFF   = 30;
   // Extra bytes inserted by one 802.1Q tag.
   localparam logic [11:0] VLAN_TAG_LEN    = 12'd4;
   // Byte index saturates here.
   localparam logic [11:0] IDX_MAX         = 12'hFFF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ETH  = 2'd1,
      S_PTP  = 2'd2,
      S_DROP = 2'd3
   } ptp_state_e;

   typedef struct packed {
      logic [3:0]  msg_type;
      logic [15:0] seq_id;
   } ptp_rec_t;

endpackage

// File: rtl/ptp_rec_fifo.sv
// -----------------------------------------------------------------------------
// ptp_rec_fifo
// Synchronous record FIFO. A push while full is accepted only when a pop
// happens in the same cycle (the pop frees the slot first).
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, data_i      write request and record word
//   pop_i               read request (ignored when empty)
//   data_o              head entry, stable until popped
//   full_o, empty_o     occupancy flags
// -----------------------------------------------------------------------------
module ptp_rec_fifo
   import ptp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 84
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push_s;
   logic          do_pop_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign do_pop_s  = pop_i && !empty_o;
   assign do_push_s = push_i && (!full_o || do_pop_s);
   assign data_o    = mem_q[rd_ptr_q];

   // Storage, pointers and occupancy; pointers wrap naturally (power-of-two depth).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
      end
   end

endmodule

// File: rtl/axis_ptp_msg_parser.sv
// -----------------------------------------------------------------------------
// axis_ptp_msg_parser
// Passive tap on an 8-bit AXI-Stream. Recognises PTP-over-Ethernet frames,
// extracts messageType and sequenceId, pairs them with the time captured at
// start of frame, and queues the result as a record.
// Build option: define PTP_VLAN_EN to accept one 802.1Q tag before the
// ethertype (all PTP offsets then shift by 4 bytes). Without it a TPID
// ethertype is treated as a non-PTP frame.
// Ports:
//   axis_aclk, rst                   clock, synchronous active-high reset
//   axis_tvalid/tready/tlast/tdata   monitored stream (never back-pressured)
//   is_ptp_frame                     destination-MAC match, valid from byte 6
//   ts_in                            free-running PTP time
//   rec_valid/rec_ready              record handshake
//   rec_msg_type/rec_seq_id/rec_ts   head record fields
//   drop_count                       records lost to FIFO full (saturating)
// -----------------------------------------------------------------------------
module axis_ptp_msg_parser
   import ptp_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TS_WIDTH   = 64
) (
   input  logic                axis_aclk,
   input  logic                rst,
   input  logic                axis_tvalid,
   input  logic                axis_tready,
   input  logic                axis_tlast,
   input  logic [7:0]          axis_tdata,
   input  logic                is_ptp_frame,
   input  logic [TS_WIDTH-1:0] ts_in,
   output logic                rec_valid,
   input  logic                rec_ready,
   output logic [3:0]          rec_msg_type,
   output logic [15:0]         rec_seq_id,
   output logic [TS_WIDTH-1:0] rec_ts,
   output logic [15:0]         drop_count
);

   localparam int          RW           = $bits(ptp_rec_t) + TS_WIDTH;
   localparam logic [11:0] IDX_ETYPE_HI = 12'd12;
   localparam logic [11:0] IDX_ETYPE_LO = 12'd13;
   localparam logic [11:0] IDX_MSG      = 12'(ETH_HDR_LEN + PTP_MSGTYPE_OFF);
   localparam logic [11:0] IDX_SEQ_HI   = 12'(ETH_HDR_LEN + PTP_SEQID_OFF);
   localparam logic [11:0] IDX_SEQ_LO   = IDX_SEQ_HI + 12'd1;

   ptp_state_e          state_q;
   ptp_state_e          state_d;
   logic [11:0]         idx_q;
   logic [TS_WIDTH-1:0] ts_q;
   logic [7:0]          etype_hi_q;
   logic [3:0]          msg_q;
   logic [15:0]         seq_q;
   logic [15:0]         drop_q;
   logic [11:0]         off_s;
   logic                beat_s;
   logic [15:0]         etype_s;
   logic                push_s;
   logic                full_s;
   logic                empty_s;
   logic                drop_s;
   ptp_rec_t            push_rec_s;
   ptp_rec_t            head_rec_s;
   logic [RW-1:0]       head_s;

`ifdef PTP_VLAN_EN
   logic                vlan_q;
   assign off_s = vlan_q ? VLAN_TAG_LEN : 12'd0;
`else
   assign off_s = 12'd0;
`endif

   assign beat_s  = axis_tvalid && axis_tready;
   assign etype_s = {etype_hi_q, axis_tdata};

   // The low sequenceId byte may arrive on the very tlast beat, so bypass it.
   assign push_rec_s.msg_type = msg_q;
   assign push_rec_s.seq_id   = {seq_q[15:8],
                                 (idx_q == IDX_SEQ_LO + off_s) ? axis_tdata : seq_q[7:0]};

   assign drop_s = push_s && full_s && !rec_ready;

   // FSM state register.
   always_ff @(posedge axis_aclk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state and record push request.
   always_comb begin
      state_d = state_q;
      push_s  = 1'b0;
      if (beat_s) begin
         if (axis_tlast) begin
            state_d = S_IDLE;
            if (state_q == S_PTP && idx_q >= IDX_SEQ_LO + off_s) begin
               push_s = 1'b1;
            end else begin
               push_s = 1'b0;
            end
         end else begin
            case (state_q)
               S_IDLE: state_d = S_ETH;
               S_ETH: begin
                  if (idx_q == IDX_ETYPE_HI && !is_ptp_frame) begin
                     state_d = S_DROP;
                  end else if (idx_q == IDX_ETYPE_LO + off_s) begin
                     if (etype_s == PTP_ETHERTYPE) begin
                        state_d = S_PTP;
`ifdef PTP_VLAN_EN
                     end else if (!vlan_q && etype_s == VLAN_TPID) begin
                        state_d = S_ETH;
`endif
                     end else begin
                        state_d = S_DROP;
                     end
                  end else begin
                     state_d = S_ETH;
                  end
               end
               S_PTP:   state_d = S_PTP;
               S_DROP:  state_d = S_DROP;
               default: state_d = S_IDLE;
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // Byte index, SOF timestamp and header field capture.
   always_ff @(posedge axis_aclk) begin
      if (rst) begin
         idx_q      <= 12'd0;
         ts_q       <= '0;
         etype_hi_q <= 8'd0;
         msg_q      <= 4'd0;
         seq_q      <= 16'd0;
`ifdef PTP_VLAN_EN
         vlan_q     <= 1'b0;
`endif
      end else if (beat_s) begin
         if (axis_tlast) begin
            idx_q <= 12'd0;
         end else if (idx_q != IDX_MAX) begin
            idx_q <= idx_q + 12'd1;
         end
         if (state_q == S_IDLE) begin
            ts_q <= ts_in;
         end
         if (state_q == S_ETH && idx_q == IDX_ETYPE_HI + off_s) begin
            etype_hi_q <= axis_tdata;
         end
`ifdef PTP_VLAN_EN
         if (axis_tlast || state_q == S_IDLE) begin
            vlan_q <= 1'b0;
         end else if (state_q == S_ETH && !vlan_q && idx_q == IDX_ETYPE_LO &&
                      etype_s == VLAN_TPID) begin
            vlan_q <= 1'b1;
         end
`endif
         if (state_q == S_PTP) begin
            if (idx_q == IDX_MSG + off_s) begin
               msg_q <= axis_tdata[3:0];
            end
            if (idx_q == IDX_SEQ_HI + off_s) begin
               seq_q[15:8] <= axis_tdata;
            end
            if (idx_q == IDX_SEQ_LO + off_s) begin
               seq_q[7:0] <= axis_tdata;
            end
         end
      end
   end

   // Saturating count of records discarded because the FIFO was full.
   always_ff @(posedge axis_aclk) begin
      if (rst) begin
         drop_q <= 16'd0;
      end else if (drop_s && drop_q != 16'hFFFF) begin
         drop_q <= drop_q + 16'd1;
      end
   end

   ptp_rec_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (RW)
   ) u_fifo (
      .clk_i   (axis_aclk),
      .rst_i   (rst),
      .push_i  (push_s),
      .data_i  ({push_rec_s, ts_q}),
      .pop_i   (rec_ready),
      .data_o  (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

   assign {head_rec_s, rec_ts} = head_s;
   assign rec_msg_type         = head_rec_s.msg_type;
   assign rec_seq_id           = head_rec_s.seq_id;
   assign rec_valid            = !empty_s;
   assign drop_count           = drop_q;

endmodule

// File: doc/axis_ptp_msg_parser.md
AXIS_PTP_MSG_PARSER -- requirements
Module: axis_ptp_msg_parser

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, record FIFO depth; power of two, range 2..16.
REQ-002 Parameter TS_WIDTH, default 64, width of the SOF timestamp.
REQ-003 axis_aclk  in  1  clock; reset rst, synchronous, active-high; clock axis_aclk.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 axis_tvalid, axis_tready, axis_tlast  in  1 each  monitored 8-bit AXIS stream; passive tap, never back-pressures.
REQ-006 axis_tdata  in  8  stream byte.
REQ-007 is_ptp_frame  in  1  PTP destination-MAC flag from the upstream checker; valid from byte 6 to end of frame.
REQ-008 ts_in  in  TS_WIDTH  free-running PTP time.
REQ-009 rec_valid  out  1; rec_ready  in  1  record handshake.
REQ-010 rec_msg_type  out  4; rec_seq_id  out  16; rec_ts  out  TS_WIDTH  record fields.
REQ-011 drop_count  out  16  records lost to FIFO full.

Function
REQ-012 A beat is accepted only when axis_tvalid && axis_tready; byte index counts accepted beats from 0, saturating at 4095, and clears after an accepted tlast.
REQ-013 FSM states: S_IDLE, S_ETH, S_PTP, S_DROP.
REQ-014 S_IDLE: first accepted beat latches ts_in into the frame timestamp and moves to S_ETH; a tlast on that same beat returns to S_IDLE with no record.
REQ-015 S_ETH: at index 12, is_ptp_frame==0 moves to S_DROP; at index 13, ethertype {byte12,byte13}==16'h88F7 moves to S_PTP, any other value moves to S_DROP.
REQ-016 S_PTP: index 14 captures rec_msg_type = byte[3:0]; indices 44 and 45 capture rec_seq_id high and low bytes.
REQ-017 Accepted tlast in S_PTP with index >= 45 pushes {msg_type, seq_id, ts} into the FIFO; a tlast with index < 45 (short frame) pushes nothing.
REQ-018 Accepted tlast in any state returns the FSM to S_IDLE on the next cycle.
REQ-019 A push while the FIFO is full and rec_ready==0 discards the record and increments drop_count, saturating at 16'hFFFF.
REQ-020 Push while full with rec_ready==1 in the same cycle succeeds; pop frees the slot first.
REQ-021 rec_valid = FIFO not empty; the head is held stable until rec_valid && rec_ready.
REQ-022 Latency: rec_valid rises on the cycle after the tlast beat when the FIFO was empty.
REQ-023 Frames shorter than 14 bytes produce no record and no drop count.

Reset
REQ-024 Reset clears FSM to S_IDLE, byte index to 0, FIFO to empty, rec_valid to 0, rec_msg_type, rec_seq_id, rec_ts to 0, and drop_count to 0.
REQ-025 Reset mid-frame discards any partial record; the next accepted beat is treated as SOF.

Configuration
REQ-026 Macro PTP_VLAN_EN.
- Defined: an ethertype of 16'h8100 at index 12-13 is skipped; the real ethertype is checked at index 16-17, and all PTP offsets shift by +4 (msg_type at 18, seq_id at 48/49, minimum tlast index 49).
- Undefined: 16'h8100 sends the FSM to S_DROP.

Structure
REQ-027 Shared package ptp_pkg: PTP_ETHERTYPE, VLAN_TPID, the PTP header offsets (message type 0, sequenceId 30), the FSM state enum, and the record struct type.
REQ-028 Sub-module ptp_rec_fifo: synchronous FIFO, FIFO_DEPTH entries, push, pop, full and empty flags; the FSM, capture registers, and drop counter stay in the top module.

Verification
REQ-029 60-byte PTP Sync frame (MAC 01:80:C2:00:00:0E, ethertype 88F7, byte14=0x00, seq 0x1234), ts_in=100 at SOF -> one record {0, 0x1234, 100}.
REQ-030 60-byte IPv4 frame (ethertype 0800) with is_ptp_frame=1 -> no record; FSM reaches S_DROP at index 13.
REQ-031 Five PTP frames, rec_ready=0, FIFO_DEPTH=4 -> 4 records held, drop_count=1; with rec_ready=1 they drain in arrival order.
REQ-032 PTP frame with tlast at index 30 -> no record, drop_count unchanged.
REQ-033 With PTP_VLAN_EN: tagged frame (8100, VID 5, then 88F7, msg 0x9, seq 0xBEEF) -> record {9, 0xBEEF}; without the macro -> no record.
REQ-034 Random axis_tvalid gaps plus rst asserted at index 20, then a clean frame -> exactly one correct record, drop_count=0.
